// File: rtl/cmprs_afi_mux_eof_status.sv
// Purpose: per-channel frame-end pointer capture, frame counting, overrun and
//          sticky irq for the 4-channel AFI write-response pointer tracker.
// Latency: pointer read EOF_DELAY+1 edges after eof_written; irq 2 edges later;
//          status_rd 1 cycle after status_ra. No backpressure: eofs that arrive
//          before a channel's capture completes are merged and flagged as overrun.
//
// Ports:
//   hclk, hrst_n        clock, async active-low reset
//   en                  block enable (0 clears capture state, keeps irq/fcnt/eof_ptr/overrun)
//   eof_written[3:0]    per-channel frame-end pulses
//   chunk_ptr_ra/_rd    tracker pointer RAM read port {eof,chn}
//   irq_clr/irq         per-channel interrupt clear / sticky interrupt
//   status_ra/_rd       {sel,chn} status read; sel=0 eof_ptr, sel=1 {overrun,fcnt}
module cmprs_afi_mux_eof_status #(
  parameter int EOF_DELAY  = 7,
  parameter int FCNT_WIDTH = 16
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        en,
  input  logic [3:0]  eof_written,
  output logic [2:0]  chunk_ptr_ra,
  input  logic [26:0] chunk_ptr_rd,
  input  logic [3:0]  irq_clr,
  output logic [3:0]  irq,
  input  logic [2:0]  status_ra,
  output logic [31:0] status_rd
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_POST} state_t;

  state_t                r_state;
  logic [1:0]            r_gchn;
  logic [1:0]            r_rr_ptr;     // first channel searched by the arbiter
  logic [3:0]            r_pending;
  logic [3:0]            r_overrun;
  logic [3:0]            r_cd      [4];
  logic [26:0]           r_eof_ptr [4];
  logic [FCNT_WIDTH-1:0] r_fcnt    [4];

  logic [3:0]  w_eof;
  logic [3:0]  w_ready;
  logic [3:0]  w_busy;
  logic [3:0]  w_irq_set;
  logic [3:0]  w_ovr_set;
  logic [1:0]  w_grant;
  logic [1:0]  w_idx;
  logic        w_any;
  logic [31:0] w_stat;

  assign w_eof = eof_written & {4{en}};

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_ready[c] = r_pending[c] && (r_cd[c] == 4'd0);
    end
  end

  // Channel currently inside its READ/POST window; an eof here must re-arm it.
  assign w_busy    = (r_state != S_IDLE) ? (4'b0001 << r_gchn) : 4'b0000;
  assign w_irq_set = (en && r_state == S_POST) ? (4'b0001 << r_gchn) : 4'b0000;
  assign w_ovr_set = w_eof & (r_pending | w_busy);

  // Round-robin: scan from r_rr_ptr downward in priority so the smallest
  // offset from the pointer is the last (winning) assignment.
  always_comb begin
    w_grant = r_rr_ptr;
    w_any   = 1'b0;
    w_idx   = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr_ptr + 2'(i);
      if (w_ready[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end

  // Capture FSM
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_state      <= S_IDLE;
      r_gchn       <= 2'd0;
      r_rr_ptr     <= 2'd0;
      chunk_ptr_ra <= 3'd0;
    end else if (!en) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            chunk_ptr_ra <= {1'b1, w_grant};
            r_gchn       <= w_grant;
            r_rr_ptr     <= w_grant + 2'd1;
            r_state      <= S_READ;
          end
        end
        S_READ:  r_state <= S_POST;
        S_POST:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-channel capture state
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      r_pending <= 4'd0;
      r_overrun <= 4'd0;
      irq       <= 4'd0;
      for (int c = 0; c < 4; c++) begin
        r_cd[c]      <= 4'd0;
        r_eof_ptr[c] <= 27'd0;
        r_fcnt[c]    <= '0;
      end
    end else begin
      if (en && r_state == S_READ) begin
        r_eof_ptr[r_gchn] <= chunk_ptr_rd;
      end
      for (int c = 0; c < 4; c++) begin
        if (!en) begin
          r_pending[c] <= 1'b0;
          r_cd[c]      <= 4'd0;
        end else if (w_eof[c]) begin
          r_pending[c] <= 1'b1;
          r_cd[c]      <= 4'(EOF_DELAY);
          r_fcnt[c]    <= r_fcnt[c] + FCNT_WIDTH'(1);
        end else begin
          if (r_cd[c] != 4'd0) begin
            r_cd[c] <= r_cd[c] - 4'd1;
          end
          // A nonzero countdown here means an eof landed in the grant cycle:
          // keep pending so the newer pointer gets its own capture.
          if (r_state == S_READ && r_gchn == 2'(c) && r_cd[c] == 4'd0) begin
            r_pending[c] <= 1'b0;
          end
        end

        if (w_irq_set[c]) begin
          irq[c] <= 1'b1;
        end else if (irq_clr[c]) begin
          irq[c] <= 1'b0;
        end

        if (w_ovr_set[c]) begin
          r_overrun[c] <= 1'b1;
        end else if (irq_clr[c] && !w_irq_set[c]) begin
          r_overrun[c] <= 1'b0;
        end
      end
    end
  end

  // Status read port
  always_comb begin
    w_stat = 32'd0;
    if (status_ra[2]) begin
      w_stat[FCNT_WIDTH-1:0] = r_fcnt[status_ra[1:0]];
      w_stat[31]             = r_overrun[status_ra[1:0]];
    end else begin
      w_stat[26:0] = r_eof_ptr[status_ra[1:0]];
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      status_rd <= 32'd0;
    end else begin
      status_rd <= w_stat;
    end
  end

endmodule

// File: tb/tb_cmprs_afi_mux_eof_status.sv
// Directed bench for cmprs_afi_mux_eof_status with a tracker pointer-RAM model.
module tb_cmprs_afi_mux_eof_status;

  localparam int FW = 4;

  logic        hclk;
  logic        hrst_n;
  logic        en;
  logic [3:0]  eof_written;
  logic [2:0]  chunk_ptr_ra;
  logic [26:0] chunk_ptr_rd;
  logic [3:0]  irq_clr;
  logic [3:0]  irq;
  logic [2:0]  status_ra;
  logic [31:0] status_rd;

  logic [26:0] mem [8];
  int checks = 0;
  int errors = 0;

  assign chunk_ptr_rd = mem[chunk_ptr_ra];

  cmprs_afi_mux_eof_status #(.EOF_DELAY(7), .FCNT_WIDTH(FW)) dut (
    .hclk         (hclk),
    .hrst_n       (hrst_n),
    .en           (en),
    .eof_written  (eof_written),
    .chunk_ptr_ra (chunk_ptr_ra),
    .chunk_ptr_rd (chunk_ptr_rd),
    .irq_clr      (irq_clr),
    .irq          (irq),
    .status_ra    (status_ra),
    .status_rd    (status_rd)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    eof_written = m;
    tick();
    eof_written = 4'd0;
  endtask

  task automatic rd_status(input logic [2:0] a, input string tag, input logic [31:0] exp);
    status_ra = a;
    tick();
    chk(tag, status_rd, exp);
  endtask

  initial begin
    hrst_n = 1'b0; en = 1'b0; eof_written = 4'd0; irq_clr = 4'd0; status_ra = 3'd0;
    for (int i = 0; i < 8; i++) mem[i] = 27'd0;
    mem[4] = 27'h0000100; mem[5] = 27'h0000101; mem[6] = 27'h0000102; mem[7] = 27'h0000103;

    // Reset state
    ticks(3);
    chk("rst_ra", 32'(chunk_ptr_ra), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_status", status_rd, 32'd0);
    hrst_n = 1'b1; en = 1'b1;
    ticks(2);

    // All four channels at once: 0,1,2,3 at 3-cycle spacing
    pulse(4'hF);
    ticks(8);  chk("all_ra_c0", 32'(chunk_ptr_ra), 32'd4);
    ticks(3);  chk("all_ra_c1", 32'(chunk_ptr_ra), 32'd5);
    ticks(2);  chk("all_irq_mid", 32'(irq), 32'h3);
    ticks(4);  chk("all_ra_c3", 32'(chunk_ptr_ra), 32'd7);
    ticks(2);  chk("all_irq_done", 32'(irq), 32'hF);
    rd_status(3'b011, "all_ptr3", 32'h00000103);
    irq_clr = 4'hF; tick(); irq_clr = 4'd0;
    chk("all_irq_clr", 32'(irq), 32'h0);

    // Follow-up ch1+ch3 after last grant 3: ch1 then ch3
    pulse(4'b1010);
    ticks(8);  chk("rr_first", 32'(chunk_ptr_ra), 32'd5);
    ticks(3);  chk("rr_second", 32'(chunk_ptr_ra), 32'd7);
    ticks(2);  chk("rr_irq", 32'(irq), 32'hA);
    irq_clr = 4'hF; tick(); irq_clr = 4'd0;

    // Single eof on ch2
    mem[6] = 27'h00ABCDE;
    pulse(4'b0100);
    ticks(7);  chk("one_ra_early", 32'(chunk_ptr_ra), 32'd7);
    tick();    chk("one_ra", 32'(chunk_ptr_ra), 32'd6);
    tick();    chk("one_irq_early", 32'(irq), 32'h0);
    tick();    chk("one_irq", 32'(irq), 32'h4);
    rd_status(3'b010, "one_ptr2", 32'h000ABCDE);
    rd_status(3'b110, "one_fcnt2", 32'h00000002);
    irq_clr = 4'b0100; tick(); irq_clr = 4'd0;
    chk("one_irq_clr", 32'(irq), 32'h0);

    // Ch0 twice, 3 cycles apart: one capture after the second pulse
    mem[4] = 27'h0123456;
    pulse(4'b0001);
    ticks(2);
    pulse(4'b0001);
    ticks(7);  chk("dbl_no_early", 32'(chunk_ptr_ra), 32'd6);
    tick();    chk("dbl_ra", 32'(chunk_ptr_ra), 32'd4);
    ticks(2);  chk("dbl_irq", 32'(irq), 32'h1);
    ticks(6);  chk("dbl_ra_single", 32'(chunk_ptr_ra), 32'd4);
    rd_status(3'b000, "dbl_ptr0", 32'h00123456);
    rd_status(3'b100, "dbl_ovr_fcnt", 32'h80000003);
    irq_clr = 4'b0001; tick(); irq_clr = 4'd0;
    chk("dbl_irq_clr", 32'(irq), 32'h0);
    rd_status(3'b100, "dbl_ovr_clr", 32'h00000003);

    // Eof on ch1 during its own READ; irq_clr coincident with POST set
    mem[5] = 27'h0000AAA;
    pulse(4'b0010);
    ticks(7);
    tick();    chk("rd_ra", 32'(chunk_ptr_ra), 32'd5);
    eof_written = 4'b0010;
    tick();
    eof_written = 4'd0; irq_clr = 4'b0010; mem[5] = 27'h0000BBB;
    tick();
    irq_clr = 4'd0;
    chk("rd_irq_set_wins", 32'(irq), 32'h2);
    ticks(9);
    rd_status(3'b001, "rd_ptr_second", 32'h00000BBB);
    rd_status(3'b101, "rd_ovr_fcnt", 32'h80000004);
    irq_clr = 4'hF; tick(); irq_clr = 4'd0;

    // fcnt wrap: 17 back-to-back eofs on ch3 (2 + 17 = 19 -> 3 mod 16)
    eof_written = 4'b1000;
    ticks(17);
    eof_written = 4'd0;
    ticks(12);
    chk("wrap_irq", 32'(irq), 32'h8);
    rd_status(3'b111, "wrap_fcnt3", 32'h80000003);

    // en=0 mid-countdown: no capture, eof ignored, irq retained
    pulse(4'b0001);
    ticks(3);
    en = 1'b0;
    pulse(4'b0100);
    ticks(12);
    chk("en0_irq", 32'(irq), 32'h8);
    chk("en0_ra", 32'(chunk_ptr_ra), 32'd7);
    rd_status(3'b110, "en0_fcnt2", 32'h00000002);
    en = 1'b1;
    ticks(12);
    chk("en1_irq", 32'(irq), 32'h8);
    chk("en1_ra", 32'(chunk_ptr_ra), 32'd7);

    // Async reset mid-READ
    status_ra = 3'b001;
    pulse(4'b0010);
    ticks(8);
    chk("ar_ra_read", 32'(chunk_ptr_ra), 32'd5);
    #2 hrst_n = 1'b0;
    #1;
    chk("ar_ra", 32'(chunk_ptr_ra), 32'd0);
    chk("ar_irq", 32'(irq), 32'h0);
    chk("ar_status", status_rd, 32'd0);
    ticks(2);
    hrst_n = 1'b1;
    ticks(6);
    chk("ar_no_irq", 32'(irq), 32'h0);
    rd_status(3'b111, "ar_fcnt3", 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
